id_ex_operand_stage: RTL
========================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage MIPS core; sits directly upstream of alu.
//  Captures decoded operands/controls, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives alu a_in/b_in/alu_op.
//  Detects load-use hazards, requests a front-end stall, inserts a bubble, and counts inserted bubbles for perf monitoring.
// PARAMETERS
//  DATA_W   32  datapath width (alu operand width)
//  REG_AW   5   register-index width
//  CNT_W    16  width of saturating bubble counter
// PORTS
//  clk              in   1       single clock, rising edge
//  reset            in   1       synchronous, active-high
//  id_valid         in   1       decode slot holds a real instruction
//  id_rs/id_rt/id_rd in  REG_AW  source/dest register indices
//  id_rs_data/id_rt_data in DATA_W register-file read data
//  id_imm           in   DATA_W  sign-extended immediate
//  id_alu_src       in   1       1: alu_b = immediate
//  id_alu_op        in   3       alu opcode (000 AND,001 OR,010 ADD,110 SUB,111 SLT)
//  id_reg_write/id_mem_read in 1 controls; id_uses_rt in 1: instr reads rt
//  stall_in         in   1       downstream hold (memory wait)
//  flush            in   1       squash decode slot (branch taken)
//  exmem_reg_write/exmem_rd/exmem_result in 1/REG_AW/DATA_W  EX/MEM forward source
//  memwb_reg_write/memwb_rd/memwb_result in 1/REG_AW/DATA_W  MEM/WB forward source
//  alu_a/alu_b      out  DATA_W  to alu a_in/b_in
//  ex_alu_op        out  3       to alu alu_op
//  ex_store_data    out  DATA_W  forwarded rt for sw
//  ex_rd            out  REG_AW  EX dest index
//  ex_valid/ex_reg_write/ex_mem_read out 1  EX-slot valid and controls
//  load_use_stall   out  1       freeze PC and IF/ID this cycle
//  bubble_count     out  CNT_W   bubbles inserted since reset
// BEHAVIOUR
//  Register update, priority per rising clk: reset > flush > stall_in > load_use_stall > capture.
//  - reset: every register 0; so ex_valid=ex_reg_write=ex_mem_read=0, alu_a=alu_b=0, ex_alu_op=000, bubble_count=0.
//  - flush: ex_valid, ex_reg_write, ex_mem_read <= 0; data fields don't-care; counter unchanged.
//  - stall_in (no flush): all registers hold, counter unchanged.
//  - load_use_stall: bubble: ex_valid/ex_reg_write/ex_mem_read <= 0; bubble_count += 1, saturates at all-ones.
//  - capture: all id_* fields latched; ex_valid<=id_valid; ex_reg_write/ex_mem_read <= id_* & id_valid.
//  Latency: decode -> EX outputs 1 cycle; forwarding and load_use_stall purely combinational (0 cycles).
//  load_use_stall = ~flush & ex_valid & ex_mem_read & ex_rd!=0 & id_valid &
//                   (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)). Asserts exactly 1 cycle per load-use pair.
//  Forward hit(src,r) = src_reg_write & src_rd!=0 & src_rd==r. fwdA on ex_rs: EX/MEM hit ? exmem_result :
//   MEM/WB hit ? memwb_result : ex_rs_data. fwdB same on ex_rt. EX/MEM wins when both hit. $0 never forwarded.
//  alu_a=fwdA; alu_b = ex_alu_src ? ex_imm : fwdB; ex_store_data=fwdB (independent of alu_src).
//  Outputs are driven even when ex_valid=0; consumers qualify with ex_valid / ex_reg_write.
//  Reset mid-stall or mid-bubble: reset wins; load_use_stall deasserts next cycle because ex_valid=0.
//  No widening or truncation: all data paths exactly DATA_W bits.
// TESTING
//  1 reset=1 two cycles with id_valid=1 -> ex_valid=0, ex_reg_write=0, alu_a=0, bubble_count=0.
//  2 id rs_data=5, rt_data=3, alu_op=010, alu_src=0, no hits -> next cycle alu_a=5, alu_b=3, ex_alu_op=010.
//  3 ex_rs=8; exmem rd=8 res=0x11, memwb rd=8 res=0x22 -> alu_a=0x11; exmem_reg_write=0 -> 0x22; both rd=0 -> ex_rs_data.
//  4 EX holds lw rd=9, id rs=9 -> load_use_stall=1, next cycle ex_valid=0, bubble_count=1; id rt=9 with uses_rt=0 -> no stall.
//  5 stall_in=1 for 3 cycles -> all outputs constant; flush=1 with stall_in=1 -> ex_valid=0 next cycle.
//  6 alu_src=1, imm=0xFFFFFFFC, rt forwarded 0x7 -> alu_b=0xFFFFFFFC, ex_store_data=0x7; CNT_W=2, 4 bubbles -> count=3.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage
// MIPS core. This block feeds the alu directly.
//   - Captures decoded operands and controls from the decode slot.
//   - Resolves RAW hazards by forwarding from EX/MEM (highest priority) and
//     then MEM/WB. Register $0 is never forwarded.
//   - Detects load-use hazards and raises load_use_stall, which freezes the
//     PC and IF/ID and makes this stage insert a bubble. Inserted bubbles are
//     counted in a saturating counter for perf monitoring.
//
// Ports
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   id_*                          decoded instruction in the decode slot
//   stall_in                      downstream hold: every register keeps its value
//   flush                         squash the decode slot (branch taken)
//   exmem_* / memwb_*             forwarding sources
//   alu_a, alu_b, ex_alu_op       operands and opcode for the alu
//   ex_store_data                 forwarded rt value for stores
//   ex_rd, ex_valid,
//   ex_reg_write, ex_mem_read     EX-slot destination and controls
//   load_use_stall                combinational front-end freeze request
//   bubble_count                  bubbles inserted since reset (saturating)
//
// Register update priority on each rising edge:
//   reset > flush > stall_in > load_use_stall > capture
//
// Handshake: there is no valid/ready pair here. The decode slot is consumed
// on every edge where none of reset/flush/stall_in/load_use_stall apply;
// load_use_stall is the only back-pressure this stage produces, and
// stall_in is the only back-pressure it obeys.
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src,
    input  logic [2:0]        id_alu_op,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_uses_rt,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    logic              ex_valid_q,     ex_valid_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic              ex_mem_read_q,  ex_mem_read_d;
    logic [REG_AW-1:0] ex_rs_q,        ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q,        ex_rt_d;
    logic [REG_AW-1:0] ex_rd_q,        ex_rd_d;
    logic [DATA_W-1:0] ex_rs_data_q,   ex_rs_data_d;
    logic [DATA_W-1:0] ex_rt_data_q,   ex_rt_data_d;
    logic [DATA_W-1:0] ex_imm_q,       ex_imm_d;
    logic              ex_alu_src_q,   ex_alu_src_d;
    logic [2:0]        ex_alu_op_q,    ex_alu_op_d;
    logic [CNT_W-1:0]  bubble_count_q, bubble_count_d;

    logic              lu_hit;
    logic              exmem_hit_a, memwb_hit_a;
    logic              exmem_hit_b, memwb_hit_b;
    logic [DATA_W-1:0] fwd_a, fwd_b;

    // Load-use: the EX slot holds a load whose destination the decode slot
    // reads. A flush kills the decode slot, so no stall is needed then.
    always_comb begin
        lu_hit = 1'b0;
        if (ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) && id_valid) begin
            lu_hit = (ex_rd_q == id_rs) || (id_uses_rt && (ex_rd_q == id_rt));
        end
    end

    assign load_use_stall = ~flush & lu_hit;

    // Forwarding: EX/MEM is the younger producer, so it wins over MEM/WB.
    assign exmem_hit_a = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs_q);
    assign memwb_hit_a = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs_q);
    assign exmem_hit_b = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rt_q);
    assign memwb_hit_b = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rt_q);

    always_comb begin
        fwd_a = ex_rs_data_q;
        if (exmem_hit_a)      fwd_a = exmem_result;
        else if (memwb_hit_a) fwd_a = memwb_result;

        fwd_b = ex_rt_data_q;
        if (exmem_hit_b)      fwd_b = exmem_result;
        else if (memwb_hit_b) fwd_b = memwb_result;
    end

    // Next-state for the ID/EX register. Data fields simply hold on flush
    // and bubble; only the control bits are cleared.
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_rd_d        = ex_rd_q;
        ex_rs_data_d   = ex_rs_data_q;
        ex_rt_data_d   = ex_rt_data_q;
        ex_imm_d       = ex_imm_q;
        ex_alu_src_d   = ex_alu_src_q;
        ex_alu_op_d    = ex_alu_op_q;
        bubble_count_d = bubble_count_q;

        if (flush) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
        end else if (stall_in) begin
            // hold everything
        end else if (load_use_stall) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            if (bubble_count_q != '1) begin
                bubble_count_d = bubble_count_q + 1'b1;
            end
        end else begin
            ex_valid_d     = id_valid;
            ex_reg_write_d = id_reg_write & id_valid;
            ex_mem_read_d  = id_mem_read & id_valid;
            ex_rs_d        = id_rs;
            ex_rt_d        = id_rt;
            ex_rd_d        = id_rd;
            ex_rs_data_d   = id_rs_data;
            ex_rt_data_d   = id_rt_data;
            ex_imm_d       = id_imm;
            ex_alu_src_d   = id_alu_src;
            ex_alu_op_d    = id_alu_op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_rd_q        <= '0;
            ex_rs_data_q   <= '0;
            ex_rt_data_q   <= '0;
            ex_imm_q       <= '0;
            ex_alu_src_q   <= 1'b0;
            ex_alu_op_q    <= 3'b000;
            bubble_count_q <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_rd_q        <= ex_rd_d;
            ex_rs_data_q   <= ex_rs_data_d;
            ex_rt_data_q   <= ex_rt_data_d;
            ex_imm_q       <= ex_imm_d;
            ex_alu_src_q   <= ex_alu_src_d;
            ex_alu_op_q    <= ex_alu_op_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign alu_a         = fwd_a;
    assign alu_b         = ex_alu_src_q ? ex_imm_q : fwd_b;
    assign ex_store_data = fwd_b;
    assign ex_alu_op     = ex_alu_op_q;
    assign ex_rd         = ex_rd_q;
    assign ex_valid      = ex_valid_q;
    assign ex_reg_write  = ex_reg_write_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign bubble_count  = bubble_count_q;

endmodule
